hicore_lsu_nb: RTL and testbench
================================

Name: hicore_lsu_nb

Overview:
Parametrised non-blocking load/store unit for the HiCore core. It accepts address-generated requests from the AGU and issues ICB commands through a registered command stage. A tracking FIFO holds up to OSTD outstanding requests and matches in-order responses to them. Loaded data is aligned and sign- or zero-extended, exceptions and pre-existing faults are merged into one registered writeback port toward the ROB, and flush kills in-flight writebacks without stalling the memory side.

Parameters:
XLEN, 32, data width (32 or 64)
AW, 32, address width
PTRW, 4, ROB pointer width
EXCW, 4, exception-code width; 0 means no exception
OSTD, 4, outstanding-request depth (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_valid  in  1  AGU request valid
i_ready  out  1  AGU request accepted
i_cancel  in  1  request cancelled; accepted and discarded
i_read  in  1  1 = load, 0 = store
i_unsigned  in  1  zero-extend load
i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (only legal when XLEN=64)
i_addr  in  AW  byte address
i_wdata  in  XLEN  store data, already lane-aligned
i_wmask  in  XLEN/8  store byte mask
i_ptr  in  PTRW  ROB pointer
i_excp  in  EXCW  upstream exception code
cmd_valid  out  1  ICB command valid
cmd_ready  in  1  ICB command ready
cmd_read  out  1  ICB read
cmd_addr  out  AW  ICB address
cmd_wdata  out  XLEN  ICB write data
cmd_wmask  out  XLEN/8  ICB byte mask
rsp_valid  in  1  ICB response valid
rsp_ready  out  1  ICB response ready
rsp_err  in  1  ICB bus error
rsp_rdata  in  XLEN  ICB read data
wb_valid  out  1  writeback strobe
wb_ptr  out  PTRW  writeback ROB pointer
wb_data  out  XLEN  load result; 0 for stores and faults
wb_excp  out  EXCW  writeback exception code
flush  in  1  pipeline flush from commit
busy  out  1  tracking FIFO non-empty or command stage full
ostd_cnt  out  log2(OSTD)+1  outstanding entries

Behaviour:
- Reset (rst_n=0 at a clk edge): command stage empty, tracking FIFO empty, exception buffer empty, wb_valid=0, wb_ptr/wb_data/wb_excp=0, cmd_valid=0, ostd_cnt=0. Reset mid-operation discards everything; later responses with an empty FIFO are ignored.
- Request classes, evaluated on i_valid:
  - i_cancel=1: i_ready=1, no side effect.
  - i_excp!=0: exception request; i_ready = exception buffer empty, or draining this cycle.
  - otherwise, memory request; i_ready = (command stage empty or cmd_ready) and (FIFO not full, or popping this cycle).
- Memory accept: loads the command stage, so cmd_valid rises the next cycle. It also pushes a FIFO entry {ptr, read, unsigned, size, addr low bits, kill=0} in the same cycle.
- Command stage: holds its contents until cmd_valid and cmd_ready; it is unaffected by flush, because entries already accepted must complete on the bus.
- Response path:
  - rsp_ready = FIFO non-empty.
  - On a handshake, the head entry is popped.
  - A response arriving with an empty FIFO is dropped.
  - Simultaneous push and pop when full is allowed, and ostd_cnt is unchanged.
- Load data:
  - shift rsp_rdata right by addr[log2(XLEN/8)-1:0]*8.
  - byte, half and word results are sign-extended unless unsigned; dword is passed through.
  - a word load on XLEN=64 sign-extends bit 31.
- Errors: rsp_err on a load gives wb_excp=5; on a store, wb_excp=7. In both cases wb_data=0.
- Writeback register, loaded one cycle after its source event:
  - Priority 1: rsp handshake with kill=0.
  - Priority 2: exception buffer valid, which then clears.
  - A killed response never blocks the exception buffer, so no deadlock.
  - wb_valid is a single-cycle strobe.
- Flush:
  - sets kill on every valid FIFO entry and clears the exception buffer.
  - i_valid is ignored in the flush cycle (i_ready=0 for non-cancel requests).
  - a wb_valid scheduled in the flush cycle is suppressed.
  - killed entries still drain responses, and busy stays high until they do.
- Entries pushed after flush have kill=0. Wrap-around of the FIFO pointers uses log2(OSTD)+1-bit pointers, and full = MSB differs while the low bits are equal.

Optional Feature:
HICORE_LSU_MISALIGN_EN
- Defined: a memory request whose address is not aligned to its size becomes an exception request, with code 4 for a load and 6 for a store. It issues no ICB command and is routed to the exception buffer.
- Undefined: alignment is not checked, and the low address bits are forwarded to the bus unchanged.

Test Plan:
- Word load, addr 0x100, rsp_rdata 0xDEADBEEF, XLEN=32 -> cmd_valid 1 cycle after accept; wb_valid 1 cycle after rsp; wb_data 0xDEADBEEF, wb_excp 0.
- Signed byte load at addr 0x103, rdata 0x80112233 -> wb_data 0xFFFFFF80; same access unsigned -> 0x00000080.
- Issue 4 loads with OSTD=4 and responses withheld -> ostd_cnt=4 and i_ready=0; a fifth load is accepted in the same cycle the first response pops.
- 2 loads outstanding, then flush, then responses -> no wb_valid for either; busy falls after the second response.
- Exception request (i_excp=2) in the same cycle as an unkilled rsp -> rsp writes back first, the exception 1 cycle later; both ptrs appear.
- Store with rsp_err=1 -> wb_excp=7, wb_data=0; with the macro defined, a half store at 0x101 -> wb_excp=6 and cmd_valid never asserts.

Source files
------------

// File: rtl/hicore_lsu_nb.sv
// Non-blocking load/store unit: registered ICB command stage, in-order response tracking FIFO,
// load alignment/extension and a single writeback port. Optional macro: HICORE_LSU_MISALIGN_EN.
module hicore_lsu_nb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned PTRW = 4,
  parameter int unsigned EXCW = 4,
  parameter int unsigned OSTD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_cancel,
  input  logic                     i_read,
  input  logic                     i_unsigned,
  input  logic [1:0]               i_size,
  input  logic [AW-1:0]            i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic [XLEN/8-1:0]        i_wmask,
  input  logic [PTRW-1:0]          i_ptr,
  input  logic [EXCW-1:0]          i_excp,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_read,
  output logic [AW-1:0]            cmd_addr,
  output logic [XLEN-1:0]          cmd_wdata,
  output logic [XLEN/8-1:0]        cmd_wmask,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic                     rsp_err,
  input  logic [XLEN-1:0]          rsp_rdata,
  output logic                     wb_valid,
  output logic [PTRW-1:0]          wb_ptr,
  output logic [XLEN-1:0]          wb_data,
  output logic [EXCW-1:0]          wb_excp,
  input  logic                     flush,
  output logic                     busy,
  output logic [$clog2(OSTD):0]    ostd_cnt
);

  localparam int unsigned MW = XLEN / 8;
  localparam int unsigned BW = $clog2(MW);
  localparam int unsigned LW = $clog2(OSTD);
  localparam int unsigned CW = LW + 1;

  typedef struct packed {
    logic [PTRW-1:0] ptr;
    logic            read;
    logic            uns;
    logic [1:0]      size;
    logic [BW-1:0]   lo;
  } ent_t;

  ent_t            fifo_q [OSTD];
  logic [OSTD-1:0] kill_q;
  logic [CW-1:0]   wp_q, rp_q;
  logic            exc_v_q;
  logic [PTRW-1:0] exc_ptr_q;
  logic [EXCW-1:0] exc_code_q;

  logic            fifo_empty, fifo_full, pop, rsp_wb, exc_drain;
  logic            misal, req_exc, mem_ok, acc_mem, acc_exc;
  logic [EXCW-1:0] exc_code, rsp_excp;
  logic [XLEN-1:0] shifted, ld_data;
  ent_t            head;

  assign fifo_empty = (wp_q == rp_q);
  assign fifo_full  = (wp_q[LW] != rp_q[LW]) && (wp_q[LW-1:0] == rp_q[LW-1:0]);
  assign head       = fifo_q[rp_q[LW-1:0]];
  assign pop        = rsp_valid && !fifo_empty;
  assign rsp_wb     = pop && !kill_q[rp_q[LW-1:0]];
  // A killed response never claims the writeback slot, so the buffer can always drain.
  assign exc_drain  = exc_v_q && !rsp_wb && !flush;

`ifdef HICORE_LSU_MISALIGN_EN
  always_comb begin
    misal = 1'b0;
    case (i_size)
      2'd1:    misal = i_addr[0];
      2'd2:    misal = |i_addr[1:0];
      2'd3:    misal = |i_addr[2:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  assign req_exc  = (i_excp != '0) || misal;
  assign exc_code = (i_excp != '0) ? i_excp : (i_read ? EXCW'(4) : EXCW'(6));
  assign mem_ok   = (!cmd_valid || cmd_ready) && (!fifo_full || pop);

  always_comb begin
    i_ready = 1'b0;
    if (i_cancel)     i_ready = 1'b1;
    else if (flush)   i_ready = 1'b0;
    else if (req_exc) i_ready = !exc_v_q || exc_drain;
    else              i_ready = mem_ok;
  end

  assign acc_mem = i_valid && i_ready && !i_cancel && !req_exc;
  assign acc_exc = i_valid && i_ready && !i_cancel && req_exc;

  // Load alignment and extension of the head entry's response.
  assign shifted = rsp_rdata >> {head.lo, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (head.size)
      2'd0:    ld_data = head.uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ld_data = head.uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ld_data = head.uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ld_data = shifted;
    endcase
  end

  assign rsp_excp = rsp_err ? (head.read ? EXCW'(5) : EXCW'(7)) : '0;

  assign rsp_ready = !fifo_empty;
  assign busy      = !fifo_empty || cmd_valid;
  assign ostd_cnt  = wp_q - rp_q;

  // Tracking payload needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (acc_mem) begin
      fifo_q[wp_q[LW-1:0]] <= '{ptr: i_ptr, read: i_read, uns: i_unsigned,
                                 size: i_size, lo: i_addr[BW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_wmask  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      kill_q     <= '0;
      exc_v_q    <= 1'b0;
      exc_ptr_q  <= '0;
      exc_code_q <= '0;
      wb_valid   <= 1'b0;
      wb_ptr     <= '0;
      wb_data    <= '0;
      wb_excp    <= '0;
    end else begin
      if (acc_mem) begin
        cmd_valid <= 1'b1;
        cmd_read  <= i_read;
        cmd_addr  <= i_addr;
        cmd_wdata <= i_wdata;
        cmd_wmask <= i_wmask;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      if (acc_mem) wp_q <= wp_q + CW'(1);
      if (pop)     rp_q <= rp_q + CW'(1);

      if (flush)        kill_q <= '1;
      else if (acc_mem) kill_q[wp_q[LW-1:0]] <= 1'b0;

      if (flush) begin
        exc_v_q <= 1'b0;
      end else if (acc_exc) begin
        exc_v_q    <= 1'b1;
        exc_ptr_q  <= i_ptr;
        exc_code_q <= exc_code;
      end else if (exc_drain) begin
        exc_v_q <= 1'b0;
      end

      wb_valid <= !flush && (rsp_wb || exc_v_q);
      if (!flush && rsp_wb) begin
        wb_ptr  <= head.ptr;
        wb_data <= (head.read && !rsp_err) ? ld_data : '0;
        wb_excp <= rsp_excp;
      end else if (!flush && exc_v_q) begin
        wb_ptr  <= exc_ptr_q;
        wb_data <= '0;
        wb_excp <= exc_code_q;
      end
    end
  end

endmodule

// File: tb/tb_hicore_lsu_nb.sv
// Bench for hicore_lsu_nb (XLEN=32, OSTD=4): directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_hicore_lsu_nb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, i_cancel, i_read, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_wmask, i_ptr, i_excp;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_valid;
  logic [3:0]  wb_ptr, wb_excp;
  logic [31:0] wb_data;
  logic        flush, busy;
  logic [2:0]  ostd_cnt;

  int checks = 0;
  int failures = 0;

  hicore_lsu_nb dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_cancel(i_cancel), .i_read(i_read),
    .i_unsigned(i_unsigned), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wmask(i_wmask), .i_ptr(i_ptr), .i_excp(i_excp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .wb_valid(wb_valid), .wb_ptr(wb_ptr), .wb_data(wb_data), .wb_excp(wb_excp),
    .flush(flush), .busy(busy), .ostd_cnt(ostd_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: what the unit holds after the most recent clock edge.
  typedef struct {
    logic [3:0]  ptr;
    bit          read;
    bit          uns;
    bit [1:0]    size;
    bit [31:0]   addr;
    bit          kill;
  } ment_t;

  ment_t       mq[$];
  bit          m_cmd_v;
  bit          m_cmd_read;
  logic [31:0] m_cmd_addr, m_cmd_wdata;
  logic [3:0]  m_cmd_wmask;
  bit          m_exc_v;
  logic [3:0]  m_exc_ptr, m_exc_code;
  bit          m_wb_v;
  logic [3:0]  m_wb_ptr, m_wb_excp;
  logic [31:0] m_wb_data;

  logic [31:0] r_data;
  logic [3:0]  r_excp, r_ptr;
  logic        r_v;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_ref(input logic [31:0] rdata, input logic [31:0] addr,
                                           input bit [1:0] size, input bit uns);
    longint unsigned v, mask;
    int nb;
    v    = 64'(rdata) >> ((addr % 4) * 8);
    nb   = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask = (64'd1 << nb) - 64'd1;
    v    = v & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic idle();
    i_valid = 0; i_cancel = 0; i_read = 0; i_unsigned = 0; i_size = 0; i_addr = 0;
    i_wdata = 0; i_wmask = 0; i_ptr = 0; i_excp = 0; cmd_ready = 0; rsp_valid = 0;
    rsp_err = 0; rsp_rdata = 0; flush = 0;
  endtask

  // Check every output against the model for the current inputs, then advance one cycle.
  task automatic step();
    bit exp_rdy, pop, rsp_wb, drain, exc_req, acc_mem, acc_exc, full, empty, misal;
    logic [3:0] code;
    #1;
    if (!rst_n) begin
      mq.delete(); m_cmd_v = 0; m_exc_v = 0; m_wb_v = 0;
      @(negedge clk);
      return;
    end
    empty  = (mq.size() == 0);
    full   = (mq.size() == 4);
    pop    = rsp_valid && !empty;
    rsp_wb = 0;
    if (pop) rsp_wb = !mq[0].kill;
    drain  = m_exc_v && !rsp_wb && !flush;
    misal  = 0;
`ifdef HICORE_LSU_MISALIGN_EN
    misal = (i_size == 2'd1 && i_addr[0]) || (i_size == 2'd2 && i_addr[1:0] != 2'd0);
`endif
    exc_req = (i_excp != 0) || misal;
    code    = (i_excp != 0) ? i_excp : (i_read ? 4'd4 : 4'd6);
    if (i_cancel)     exp_rdy = 1;
    else if (flush)   exp_rdy = 0;
    else if (exc_req) exp_rdy = !m_exc_v || drain;
    else              exp_rdy = (!m_cmd_v || cmd_ready) && (!full || pop);

    if (i_valid) chk("i_ready", 64'(i_ready), 64'(exp_rdy));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_cmd_v));
    if (m_cmd_v) begin
      chk("cmd_read", 64'(cmd_read), 64'(m_cmd_read));
      chk("cmd_addr", 64'(cmd_addr), 64'(m_cmd_addr));
      chk("cmd_wdata", 64'(cmd_wdata), 64'(m_cmd_wdata));
      chk("cmd_wmask", 64'(cmd_wmask), 64'(m_cmd_wmask));
    end
    chk("rsp_ready", 64'(rsp_ready), 64'(!empty));
    chk("busy", 64'(busy), 64'(!empty || m_cmd_v));
    chk("ostd_cnt", 64'(ostd_cnt), 64'(mq.size()));
    chk("wb_valid", 64'(wb_valid), 64'(m_wb_v));
    if (m_wb_v) begin
      chk("wb_ptr", 64'(wb_ptr), 64'(m_wb_ptr));
      chk("wb_data", 64'(wb_data), 64'(m_wb_data));
      chk("wb_excp", 64'(wb_excp), 64'(m_wb_excp));
    end

    acc_mem = i_valid && !i_cancel && !flush && !exc_req && exp_rdy;
    acc_exc = i_valid && !i_cancel && !flush && exc_req && exp_rdy;

    m_wb_v = 0;
    if (!flush && rsp_wb) begin
      m_wb_v    = 1;
      m_wb_ptr  = mq[0].ptr;
      m_wb_excp = rsp_err ? (mq[0].read ? 4'd5 : 4'd7) : 4'd0;
      m_wb_data = (mq[0].read && !rsp_err) ?
                  load_ref(rsp_rdata, mq[0].addr, mq[0].size, mq[0].uns) : 32'd0;
    end else if (!flush && m_exc_v) begin
      m_wb_v = 1; m_wb_ptr = m_exc_ptr; m_wb_excp = m_exc_code; m_wb_data = 0;
    end

    if (flush) m_exc_v = 0;
    else begin
      if (drain) m_exc_v = 0;
      if (acc_exc) begin m_exc_v = 1; m_exc_ptr = i_ptr; m_exc_code = code; end
    end

    if (acc_mem) begin
      m_cmd_v = 1; m_cmd_read = i_read; m_cmd_addr = i_addr;
      m_cmd_wdata = i_wdata; m_cmd_wmask = i_wmask;
    end else if (cmd_ready) m_cmd_v = 0;

    if (pop) void'(mq.pop_front());
    if (flush) foreach (mq[k]) mq[k].kill = 1;
    if (acc_mem) mq.push_back('{ptr: i_ptr, read: i_read, uns: i_unsigned, size: i_size,
                                addr: i_addr, kill: 0});
    @(negedge clk);
  endtask

  // One accepted request, issued and answered in the following cycle; captures the writeback.
  task automatic xact(input bit rd, input bit uns, input bit [1:0] size, input logic [31:0] addr,
                      input logic [3:0] ptr, input logic [31:0] rdata, input bit err);
    idle(); i_valid = 1; i_read = rd; i_unsigned = uns; i_size = size; i_addr = addr;
    i_ptr = ptr; i_wdata = 32'hCAFE_0000 | 32'(ptr); i_wmask = 4'hF; cmd_ready = 1;
    step();
    chk("x_cmd_valid", 64'(cmd_valid), 64'd1);
    idle(); cmd_ready = 1; rsp_valid = 1; rsp_rdata = rdata; rsp_err = err;
    step();
    r_v = wb_valid; r_data = wb_data; r_excp = wb_excp; r_ptr = wb_ptr;
    idle(); step();
    chk("x_wb_strobe", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_ptr", 64'(wb_ptr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_excp", 64'(wb_excp), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_ostd_cnt", 64'(ostd_cnt), 64'd0);

    // Word load and byte loads with sign/zero extension.
    xact(1, 0, 2'd2, 32'h100, 4'd1, 32'hDEADBEEF, 0);
    chk("lw_v", 64'(r_v), 64'd1);
    chk("lw_data", 64'(r_data), 64'hDEADBEEF);
    chk("lw_excp", 64'(r_excp), 64'd0);
    xact(1, 0, 2'd0, 32'h103, 4'd2, 32'h80112233, 0);
    chk("lb_data", 64'(r_data), 64'hFFFFFF80);
    xact(1, 1, 2'd0, 32'h103, 4'd3, 32'h80112233, 0);
    chk("lbu_data", 64'(r_data), 64'h00000080);
    xact(1, 0, 2'd1, 32'h102, 4'd4, 32'h9ABC1234, 0);
    chk("lh_data", 64'(r_data), 64'hFFFF9ABC);

    // Fill the tracking FIFO; a fifth load enters only alongside a pop.
    idle(); cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1; i_read = 1; i_size = 2'd2; i_addr = 32'(i * 4); i_ptr = 4'(i);
      step();
    end
    chk("full_cnt", 64'(ostd_cnt), 64'd4);
    i_valid = 1; i_read = 1; i_size = 2'd2; i_addr = 32'h40; i_ptr = 4'd4; cmd_ready = 1;
    #1 chk("full_block", 64'(i_ready), 64'd0);
    step();
    rsp_valid = 1; rsp_rdata = 32'h0000_0011;
    #1 chk("full_pop_accept", 64'(i_ready), 64'd1);
    step();
    chk("full_cnt_same", 64'(ostd_cnt), 64'd4);
    idle(); cmd_ready = 1; rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin rsp_rdata = $urandom; step(); end
    idle(); step();

    // Flush with two loads outstanding: responses drain silently.
    idle(); cmd_ready = 1; i_valid = 1; i_read = 1; i_size = 2'd2; i_ptr = 4'd5; step();
    i_ptr = 4'd6; step();
    idle(); cmd_ready = 1; step();
    idle(); flush = 1; step();
    idle(); rsp_valid = 1; rsp_rdata = 32'h1111_2222; step();
    chk("fl_busy1", 64'(busy), 64'd1);
    chk("fl_wb1", 64'(wb_valid), 64'd0);
    step();
    chk("fl_busy0", 64'(busy), 64'd0);
    chk("fl_wb2", 64'(wb_valid), 64'd0);
    idle(); step();
    chk("fl_wb3", 64'(wb_valid), 64'd0);

    // Exception request colliding with a live response: response writes back first.
    idle(); cmd_ready = 1; i_valid = 1; i_read = 1; i_size = 2'd2; i_addr = 32'h80; i_ptr = 4'd7;
    step();
    idle(); cmd_ready = 1; i_valid = 1; i_read = 1; i_excp = 4'd2; i_ptr = 4'd9;
    rsp_valid = 1; rsp_rdata = 32'h0000_1234;
    step();
    chk("ex_rsp_v", 64'(wb_valid), 64'd1);
    chk("ex_rsp_ptr", 64'(wb_ptr), 64'd7);
    idle(); step();
    chk("ex_exc_v", 64'(wb_valid), 64'd1);
    chk("ex_exc_ptr", 64'(wb_ptr), 64'd9);
    chk("ex_exc_code", 64'(wb_excp), 64'd2);
    idle(); step();

    // Bus errors.
    xact(0, 0, 2'd2, 32'h200, 4'd3, 32'hFFFF_FFFF, 1);
    chk("st_err_excp", 64'(r_excp), 64'd7);
    chk("st_err_data", 64'(r_data), 64'd0);
    xact(1, 0, 2'd2, 32'h204, 4'd8, 32'h1234_5678, 1);
    chk("ld_err_excp", 64'(r_excp), 64'd5);
    chk("ld_err_data", 64'(r_data), 64'd0);

`ifdef HICORE_LSU_MISALIGN_EN
    idle(); i_valid = 1; i_read = 0; i_size = 2'd1; i_addr = 32'h101; i_ptr = 4'd10;
    cmd_ready = 1; step();
    chk("mis_no_cmd", 64'(cmd_valid), 64'd0);
    idle(); step();
    chk("mis_wb_v", 64'(wb_valid), 64'd1);
    chk("mis_excp", 64'(wb_excp), 64'd6);
    chk("mis_no_cmd2", 64'(cmd_valid), 64'd0);
    idle(); step();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      i_valid    = ($urandom_range(0, 1) == 1);
      i_cancel   = ($urandom_range(0, 9) == 0);
      i_excp     = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      i_read     = ($urandom_range(0, 1) == 1);
      i_unsigned = ($urandom_range(0, 1) == 1);
      i_size     = 2'($urandom_range(0, 2));
      i_addr     = $urandom;
      i_wdata    = $urandom;
      i_wmask    = 4'($urandom);
      i_ptr      = 4'($urandom);
      cmd_ready  = ($urandom_range(0, 9) < 7);
      rsp_valid  = ($urandom_range(0, 9) < 4);
      rsp_err    = ($urandom_range(0, 9) == 0);
      rsp_rdata  = $urandom;
      flush      = ($urandom_range(0, 31) == 0);
      step();
    end

    // Reset mid-operation, then a stray response into the empty FIFO.
    idle(); cmd_ready = 1; i_valid = 1; i_read = 1; i_size = 2'd2; i_ptr = 4'd1; step();
    i_ptr = 4'd2; step();
    idle(); rst_n = 0; step();
    rst_n = 1;
    chk("mrst_cnt", 64'(ostd_cnt), 64'd0);
    rsp_valid = 1; rsp_rdata = 32'h5555_AAAA; step();
    chk("mrst_wb", 64'(wb_valid), 64'd0);
    chk("mrst_cnt2", 64'(ostd_cnt), 64'd0);
    idle(); step();
    chk("mrst_wb2", 64'(wb_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
